// File: rtl/trigger_axil_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge helper for
// the trigger IP AXI4-Lite register file.
package trigger_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Replace only the bytes whose strobe bit is set; the rest keep their old value.
    function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = data[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/trigger_axil_regs.sv
// AXI4-Lite responder holding NUM_REGS 32-bit R/W registers for the trigger core,
// with per-register write pulses. Every AXI output is registered.
module trigger_axil_regs
    import trigger_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          reg_q,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    wr_state_t        wr_state;
    rd_state_t        rd_state;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic [3:0]       wr_strb;
    logic             wr_commit;
    logic [31:0]      regs [NUM_REGS];

    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic [IDX_W-1:0] aw_idx;
    logic [IDX_W-1:0] ar_idx;
    logic             unused_inputs;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign aw_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return int'(idx) < NUM_REGS;
    endfunction

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[32*g +: 32] = regs[g];
    end

    // Write channel: AW and W are captured independently; the register update
    // happens one edge after the pair is complete, together with BVALID.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state      <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            wr_commit     <= 1'b0;
            wr_idx        <= '0;
            wr_data       <= '0;
            wr_strb       <= '0;
            reg_wr_pulse  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            reg_wr_pulse <= '0;
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        wr_idx <= aw_idx;
                    end
                    if (w_hs) begin
                        wr_data <= S_AXI_WDATA;
                        wr_strb <= S_AXI_WSTRB;
                    end
                    if (aw_hs && w_hs) begin
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b0;
                        wr_commit     <= 1'b1;
                        wr_state      <= W_RESP;
                    end else if (aw_hs) begin
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        wr_state      <= W_HAVE_AW;
                    end else if (w_hs) begin
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b0;
                        wr_state      <= W_HAVE_W;
                    end else begin
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                    end
                end
                W_HAVE_AW: begin
                    if (w_hs) begin
                        wr_data      <= S_AXI_WDATA;
                        wr_strb      <= S_AXI_WSTRB;
                        S_AXI_WREADY <= 1'b0;
                        wr_commit    <= 1'b1;
                        wr_state     <= W_RESP;
                    end
                end
                W_HAVE_W: begin
                    if (aw_hs) begin
                        wr_idx        <= aw_idx;
                        S_AXI_AWREADY <= 1'b0;
                        wr_commit     <= 1'b1;
                        wr_state      <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (wr_commit) begin
                        wr_commit    <= 1'b0;
                        S_AXI_BVALID <= 1'b1;
                        if (idx_ok(wr_idx)) begin
                            regs[wr_idx]         <= strb_merge(regs[wr_idx], wr_data, wr_strb);
                            reg_wr_pulse[wr_idx] <= 1'b1;
                            S_AXI_BRESP          <= RESP_OKAY;
                        end else begin
                            S_AXI_BRESP <= RESP_SLVERR;
                        end
                    end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        wr_state      <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read channel: the register is sampled on the AR edge, so a write
    // committing on that same edge is not yet visible to the read.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state      <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        rd_state      <= R_DATA;
                        if (idx_ok(ar_idx)) begin
                            S_AXI_RDATA <= regs[ar_idx];
                            S_AXI_RRESP <= RESP_OKAY;
                        end else begin
                            S_AXI_RDATA <= '0;
                            S_AXI_RRESP <= RESP_SLVERR;
                        end
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RVALID && S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        rd_state      <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule
